score_keeper: RTL and testbench

//  Consumes the per-pixel paddle and ball video plus VGA timing strobes and judges each frame.

---
 rtl/score_keeper_pkg.sv | 23 ++
 rtl/score_keeper_bcd_counter_2d.sv | 18 +
 rtl/score_keeper.sv | 138 +++++++++++++
 tb/tb_score_keeper.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/score_keeper_pkg.sv
// Shared defaults, FSM state encoding and BCD helper for score_keeper.
package score_keeper_pkg;
  localparam int COL_W_DEF        = 10;
  localparam int MISS_COL_DEF     = 2;
  localparam int SERVE_FRAMES_DEF = 60;
  localparam int HOLD_W           = 8;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (v == 8'h99) return v;
    if (units == 4'd9) return {tens + 4'd1, 4'd0};
    return {tens, units + 4'd1};
  endfunction
endpackage

// File: rtl/score_keeper_bcd_counter_2d.sv
// Two-digit BCD counter with synchronous clear (priority) and saturating increment.
module bcd_counter_2d
  import score_keeper_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   value <= 8'h00;
    else if (clr) value <= 8'h00;
    else if (inc) value <= bcd_inc_sat(value);
  end

endmodule

// File: rtl/score_keeper.sv
// Per-frame hit/miss judge with BCD rally score and post-miss serve hold-off.
// Define SCORE_BEST_EN to build the best-rally register driving o_Best.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_PLAY | rally live; each frame end may score a hit or judge a miss
// ST_HOLD | after a miss; o_Freeze high, counts frames down to serve
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int p_COL_W        = COL_W_DEF,
  parameter int p_MISS_COL     = MISS_COL_DEF,
  parameter int p_SERVE_FRAMES = SERVE_FRAMES_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_HBlank,
  input  logic       i_VBlank,
  input  logic       i_Paddle_Video,
  input  logic       i_Ball_Video,
  output logic       o_Hit,
  output logic       o_Miss,
  output logic       o_Serve,
  output logic       o_Freeze,
  output logic [7:0] o_Score,
  output logic [7:0] o_Best
);

  localparam logic [p_COL_W-1:0] COL_ONE  = 1;
  localparam logic [p_COL_W-1:0] MISS_COL = p_COL_W'(p_MISS_COL);
  localparam logic [HOLD_W-1:0]  HOLD_ONE = 1;
  localparam logic [HOLD_W-1:0]  SERVE_N  = HOLD_W'(p_SERVE_FRAMES);

  logic [p_COL_W-1:0] col;
  logic               overlap_flag, edge_flag, prev_overlap;
  logic               set_overlap, set_edge, active;
  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold, hold_nxt;
  logic               hit_nxt, miss_nxt, serve_nxt;

  assign active      = !i_HBlank && !i_VBlank;
  assign set_overlap = active && i_Paddle_Video && i_Ball_Video;
  assign set_edge    = active && i_Ball_Video && (col < MISS_COL);

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N)                 col <= '0;
    else if (i_HReset)            col <= '0;
    else if (!i_HBlank && col != '1) col <= col + COL_ONE;
  end

  // A flag set in the evaluation cycle belongs to the next frame, so set beats clear.
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      overlap_flag <= 1'b0;
      edge_flag    <= 1'b0;
      prev_overlap <= 1'b0;
    end else begin
      if (set_overlap)   overlap_flag <= 1'b1;
      else if (i_VReset) overlap_flag <= 1'b0;
      if (set_edge)      edge_flag <= 1'b1;
      else if (i_VReset) edge_flag <= 1'b0;
      if (i_VReset)      prev_overlap <= overlap_flag;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state   <= ST_PLAY;
      hold    <= '0;
      o_Hit   <= 1'b0;
      o_Miss  <= 1'b0;
      o_Serve <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold    <= hold_nxt;
      o_Hit   <= hit_nxt;
      o_Miss  <= miss_nxt;
      o_Serve <= serve_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    serve_nxt = 1'b0;
    if (i_VReset) begin
      case (state)
        ST_PLAY: begin
          if (overlap_flag && !prev_overlap) begin
            hit_nxt = 1'b1;
          end else if (edge_flag) begin
            miss_nxt  = 1'b1;
            hold_nxt  = SERVE_N;
            state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold == HOLD_ONE) begin
            serve_nxt = 1'b1;
            hold_nxt  = '0;
            state_nxt = ST_PLAY;
          end else begin
            hold_nxt = hold - HOLD_ONE;
          end
        end
      endcase
    end
  end

  assign o_Freeze = (state == ST_HOLD);

  bcd_counter_2d u_score (
    .clk   (i_Clk),
    .rst_n (i_Rst_N),
    .inc   (hit_nxt),
    .clr   (miss_nxt),
    .value (o_Score)
  );

`ifdef SCORE_BEST_EN
  logic [7:0] best;

  // BCD digits order the same as binary, so a plain compare is valid.
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N)                       best <= 8'h00;
    else if (miss_nxt && o_Score > best) best <= o_Score;
  end

  assign o_Best = best;
`else
  assign o_Best = 8'h00;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper (default parameters).
module tb_score_keeper;

`ifdef SCORE_BEST_EN
  localparam bit BEST_ON = 1'b1;
`else
  localparam bit BEST_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hreset = 1'b0, vreset = 1'b0, hblank = 1'b1, vblank = 1'b1;
  logic       paddle = 1'b0, ball = 1'b0;
  logic       hit, miss, serve, freeze;
  logic [7:0] score, best;

  int n_cmp = 0;
  int n_err = 0;
  logic got_hit, got_miss, got_serve;

  score_keeper dut (
    .i_Clk          (clk),
    .i_Rst_N        (rst_n),
    .i_HReset       (hreset),
    .i_VReset       (vreset),
    .i_HBlank       (hblank),
    .i_VBlank       (vblank),
    .i_Paddle_Video (paddle),
    .i_Ball_Video   (ball),
    .o_Hit          (hit),
    .o_Miss         (miss),
    .o_Serve        (serve),
    .o_Freeze       (freeze),
    .o_Score        (score),
    .o_Best         (best)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 8-pixel active line; -1 leaves a slot unused.
  task automatic active_line(input int ba, input int bb, input int pd);
    @(negedge clk); vblank = 1'b0; hblank = 1'b1; hreset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      hreset = 1'b0; hblank = 1'b0;
      ball   = (k == ba) || (k == bb);
      paddle = (k == pd);
    end
    @(negedge clk); hblank = 1'b1; ball = 1'b0; paddle = 1'b0;
  endtask

  // Vertical blank then VReset; samples the pulses one cycle after VReset.
  task automatic end_frame();
    @(negedge clk); vblank = 1'b1;
    @(negedge clk); vreset = 1'b1;
    @(negedge clk); vreset = 1'b0;
    got_hit = hit; got_miss = miss; got_serve = serve;
  endtask

  task automatic frame(input int ba, input int bb, input int pd);
    active_line(ba, bb, pd);
    end_frame();
  endtask

  initial begin
    int bad;
    int hits_seen;

    repeat (3) @(negedge clk);
    check_val("reset_outputs", {hit, miss, serve, freeze, score, best}, 32'h0);
    rst_n = 1'b1;

    // reset mid-frame after an overlap was latched
    active_line(5, -1, 5);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check_val("midframe_rst_outputs", {hit, miss, serve, freeze, score, best}, 32'h0);
    rst_n = 1'b1;
    end_frame();
    check_val("midframe_rst_no_hit", got_hit, 0);
    check_val("midframe_rst_score", score, 8'h00);

    frame(5, -1, 5);
    check_val("hit_pulse", got_hit, 1);
    check_val("hit_no_miss", got_miss, 0);
    check_val("hit_score", score, 8'h01);
    @(negedge clk);
    check_val("hit_pulse_width", hit, 0);
    frame(5, -1, 5);
    check_val("span2_no_hit", got_hit, 0);
    frame(5, -1, 5);
    check_val("span3_no_hit", got_hit, 0);
    check_val("span_score", score, 8'h01);
    frame(-1, -1, -1);

    for (int i = 0; i < 6; i++) begin
      frame(5, -1, 5);
      frame(-1, -1, -1);
    end
    check_val("score_07", score, 8'h07);

    frame(1, -1, -1);
    check_val("miss_pulse", got_miss, 1);
    check_val("miss_no_hit", got_hit, 0);
    check_val("miss_score", score, 8'h00);
    check_val("miss_freeze", freeze, 1);
    check_val("best_07", best, BEST_ON ? 8'h07 : 8'h00);

    bad = 0;
    for (int i = 1; i < 60; i++) begin
      if (i == 10) frame(5, 1, 5);
      else         frame(-1, -1, -1);
      if (got_serve || got_hit || got_miss || !freeze) bad++;
    end
    check_val("hold_quiet", bad, 0);
    check_val("hold_score", score, 8'h00);
    frame(-1, -1, -1);
    check_val("serve_pulse", got_serve, 1);
    check_val("serve_unfreeze", freeze, 0);
    @(negedge clk);
    check_val("serve_pulse_width", serve, 0);

    for (int i = 0; i < 3; i++) begin
      frame(5, -1, 5);
      frame(-1, -1, -1);
    end
    check_val("score_03", score, 8'h03);
    frame(0, -1, -1);
    check_val("miss2_pulse", got_miss, 1);
    check_val("best_keeps_07", best, BEST_ON ? 8'h07 : 8'h00);

    // reset mid-HOLD
    for (int i = 0; i < 5; i++) frame(-1, -1, -1);
    active_line(-1, -1, -1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check_val("holdrst_outputs", {hit, miss, serve, freeze, score, best}, 32'h0);
    rst_n = 1'b1;
    end_frame();
    check_val("holdrst_no_pulse", {got_hit, got_miss, got_serve, freeze}, 0);

    frame(1, 5, 5);
    check_val("both_hit", got_hit, 1);
    check_val("both_no_miss", got_miss, 0);
    check_val("both_play", freeze, 0);
    check_val("both_score", score, 8'h01);
    frame(-1, -1, -1);
    check_val("edge_cleared", got_miss, 0);

    hits_seen = 0;
    for (int i = 0; i < 100; i++) begin
      frame(5, -1, 5);
      if (got_hit) hits_seen++;
      frame(-1, -1, -1);
    end
    check_val("hits_seen", hits_seen, 100);
    check_val("score_sat", score, 8'h99);

    frame(2, -1, -1);
    check_val("col2_no_miss", got_miss, 0);
    check_val("col2_play", freeze, 0);
    check_val("col2_score", score, 8'h99);
    frame(0, -1, -1);
    check_val("col0_miss", got_miss, 1);
    check_val("col0_score", score, 8'h00);
    check_val("best_99", best, BEST_ON ? 8'h99 : 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
